membus_fair_arbiter: RTL and testbench

Two-master, one-slave arbiter for the `Membus` RAM path. It replaces the fixed CPU-priority RAM arbiter between the MMIO RAM port (CPU side) and the DMA RAM master. The CPU keeps priority, but a starvation limit guarantees DMA forward progress. An in-order tag FIFO routes every downstream response back to the master that issued the request, so multiple requests can be outstanding at once.

---
 rtl/eei.sv | 10 +
 rtl/membus_if.sv | 14 +
 rtl/tag_fifo.sv | 58 +++++
 rtl/membus_fair_arbiter.sv | 109 ++++++++++
 tb/tb_membus_fair_arbiter.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eei.sv
// Shared execution-environment constants and the arbiter's response-routing tag type.
package eei;
  localparam int unsigned XLEN              = 32;
  localparam int unsigned MEMBUS_DATA_WIDTH = 32;

  typedef enum logic {
    ARB_SRC_CPU = 1'b0,
    ARB_SRC_DMA = 1'b1
  } arb_src_t;
endpackage

// File: rtl/membus_if.sv
// Membus request/response bundle: valid/ready request channel plus an in-order rvalid response.
interface membus_if;
  logic                                      valid;
  logic                                      ready;
  logic [eei::XLEN-1:0]                      addr;
  logic                                      wen;
  logic [eei::MEMBUS_DATA_WIDTH-1:0]         wdata;
  logic [eei::MEMBUS_DATA_WIDTH/8-1:0]       wmask;
  logic                                      rvalid;
  logic [eei::MEMBUS_DATA_WIDTH-1:0]         rdata;

  modport master (output valid, addr, wen, wdata, wmask, input ready, rvalid, rdata);
  modport slave  (input valid, addr, wen, wdata, wmask, output ready, rvalid, rdata);
endinterface

// File: rtl/tag_fifo.sv
// Synchronous circular FIFO; push is ignored when full and pop is ignored when empty.
module tag_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             push_ok;
  logic             pop_ok;

  always_comb begin
    full     = (count == (AW+1)'(DEPTH));
    empty    = (count == '0);
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    pop_data = mem[rptr];
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      mem[wptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (pop_ok) begin
        rptr <= rptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/membus_fair_arbiter.sv
// CPU-priority Membus arbiter with a DMA starvation limit; an in-order tag FIFO routes responses.
module membus_fair_arbiter
  import eei::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  membus_if.slave                    cpu,
  membus_if.slave                    dma,
  membus_if.master                   out,
  output logic [$clog2(DEPTH):0]     outstanding,
  output logic                       resp_orphan
);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt;
  logic          starved;
  arb_src_t      grant;
  arb_src_t      head;
  logic [0:0]    head_bits;
  logic [0:0]    grant_bits;
  logic          full;
  logic          empty;
  logic          handshake;
  logic          pop;

  always_comb begin
    starved = (starve_cnt == SW'(STARVE_LIMIT));
    grant   = ARB_SRC_CPU;
    if (dma.valid && (!cpu.valid || starved)) begin
      grant = ARB_SRC_DMA;
    end
    grant_bits = grant;
    head       = arb_src_t'(head_bits);
  end

  // Ready deliberately ignores same-cycle pops: keeps rvalid off the ready path.
  always_comb begin
    out.valid = 1'b0;
    cpu.ready = 1'b0;
    dma.ready = 1'b0;
    if (grant == ARB_SRC_DMA) begin
      out.addr  = dma.addr;
      out.wen   = dma.wen;
      out.wdata = dma.wdata;
      out.wmask = dma.wmask;
    end else begin
      out.addr  = cpu.addr;
      out.wen   = cpu.wen;
      out.wdata = cpu.wdata;
      out.wmask = cpu.wmask;
    end
    if (!rst && !full) begin
      if (grant == ARB_SRC_DMA) begin
        out.valid = dma.valid;
        dma.ready = out.ready;
      end else begin
        out.valid = cpu.valid;
        cpu.ready = out.ready;
      end
    end
    handshake = out.valid & out.ready;
  end

  always_comb begin
    pop        = ~rst & out.rvalid & ~empty;
    cpu.rvalid = pop & (head == ARB_SRC_CPU);
    dma.rvalid = pop & (head == ARB_SRC_DMA);
    cpu.rdata  = out.rdata;
    dma.rdata  = out.rdata;
  end

  tag_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (1)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (handshake),
    .push_data (grant_bits),
    .pop       (pop),
    .pop_data  (head_bits),
    .full      (full),
    .empty     (empty),
    .count     (outstanding)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (handshake) begin
      if (grant == ARB_SRC_DMA) begin
        starve_cnt <= '0;
      end else if (dma.valid && !starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_orphan <= 1'b0;
    end else if (out.rvalid && empty) begin
      resp_orphan <= 1'b1;
    end
  end
endmodule

// File: tb/tb_membus_fair_arbiter.sv
// Bench for membus_fair_arbiter: fixed vector table, directed corner sequences, random traffic vs a queue model.
module tb_membus_fair_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 3;
  localparam logic [31:0] CPU_ADDR = 32'h1000_0000;
  localparam logic [31:0] DMA_ADDR = 32'h2000_0000;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [$clog2(DEPTH):0]    outstanding;
  logic                      resp_orphan;

  membus_if cpu_if ();
  membus_if dma_if ();
  membus_if out_if ();

  membus_fair_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu         (cpu_if),
    .dma         (dma_if),
    .out         (out_if),
    .outstanding (outstanding),
    .resp_orphan (resp_orphan)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: FIFO of issuing-master ids (1 = DMA), starvation count, sticky orphan flag.
  bit mq[$];
  int m_starve = 0;
  bit m_orphan = 0;

  // Observations captured mid-cycle by step() for directed checks.
  bit          o_ov, o_cr, o_dr, o_crv, o_drv, o_orphan;
  logic [31:0] o_addr, o_crdata, o_drdata;
  int          o_cnt;
  bit          e_cacc, e_dacc;

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit cv, input bit dv, input bit ordy, input bit orv,
                      input logic [31:0] rd);
    bit full, gdma, gv, ov, pop, head;
    @(negedge clk);
    rst           = r;
    cpu_if.valid  = cv;
    dma_if.valid  = dv;
    out_if.ready  = ordy;
    out_if.rvalid = orv;
    out_if.rdata  = rd;
    #2;
    full   = (mq.size() == DEPTH);
    gdma   = dv && (!cv || m_starve == LIMIT);
    gv     = gdma ? dv : cv;
    ov     = !r && gv && !full;
    pop    = !r && orv && (mq.size() > 0);
    head   = (mq.size() > 0) ? mq[0] : 1'b0;
    e_cacc = ov && ordy && !gdma;
    e_dacc = ov && ordy && gdma;

    chk_b("out_valid", out_if.valid, ov);
    chk_b("cpu_accept", cpu_if.ready && cv, e_cacc);
    chk_b("dma_accept", dma_if.ready && dv, e_dacc);
    if (ov) begin
      chk_w("out_addr", out_if.addr, gdma ? dma_if.addr : cpu_if.addr);
      chk_w("out_wdata", out_if.wdata, gdma ? dma_if.wdata : cpu_if.wdata);
      chk_b("out_wen", out_if.wen, gdma ? dma_if.wen : cpu_if.wen);
      chk_w("out_wmask", 32'(out_if.wmask), 32'(gdma ? dma_if.wmask : cpu_if.wmask));
    end
    chk_b("cpu_rvalid", cpu_if.rvalid, pop && !head);
    chk_b("dma_rvalid", dma_if.rvalid, pop && head);
    if (pop) begin
      chk_w("resp_rdata", head ? dma_if.rdata : cpu_if.rdata, rd);
    end
    chk_w("outstanding", 32'(outstanding), mq.size());
    chk_b("resp_orphan", resp_orphan, m_orphan);

    o_ov     = out_if.valid;
    o_cr     = cpu_if.ready && cv;
    o_dr     = dma_if.ready && dv;
    o_crv    = cpu_if.rvalid;
    o_drv    = dma_if.rvalid;
    o_addr   = out_if.addr;
    o_crdata = cpu_if.rdata;
    o_drdata = dma_if.rdata;
    o_cnt    = int'(outstanding);
    o_orphan = resp_orphan;

    @(posedge clk);
    if (r) begin
      mq.delete();
      m_starve = 0;
      m_orphan = 0;
    end else begin
      if (orv && mq.size() == 0) m_orphan = 1;
      if (pop) void'(mq.pop_front());
      if (ov && ordy) begin
        mq.push_back(gdma);
        if (gdma) m_starve = 0;
        else if (dv && m_starve < LIMIT) m_starve++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  typedef struct {
    bit cv, dv, ordy, orv;
    bit e_gdma, e_ov, e_cr, e_dr, e_crv, e_drv;
    int e_cnt;
  } vec_t;

  vec_t tbl[12];
  bit cp, dp;

  initial begin
    cpu_if.valid = 1'b0; cpu_if.addr = CPU_ADDR; cpu_if.wen = 1'b0;
    cpu_if.wdata = 32'h0; cpu_if.wmask = 4'h0;
    dma_if.valid = 1'b0; dma_if.addr = DMA_ADDR; dma_if.wen = 1'b0;
    dma_if.wdata = 32'h0; dma_if.wmask = 4'h0;
    out_if.ready = 1'b0; out_if.rvalid = 1'b0; out_if.rdata = 32'h0;

    //           cv dv rdy rv | gdma ov cr dr crv drv cnt
    tbl[0]  = '{1, 1, 1, 0,   0, 1, 1, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 1, 1,   0, 1, 1, 0, 1, 0, 1};
    tbl[2]  = '{1, 1, 1, 1,   0, 1, 1, 0, 1, 0, 1};
    tbl[3]  = '{1, 1, 1, 1,   1, 1, 0, 1, 1, 0, 1};
    tbl[4]  = '{1, 1, 1, 1,   0, 1, 1, 0, 0, 1, 1};
    tbl[5]  = '{1, 1, 1, 1,   0, 1, 1, 0, 1, 0, 1};
    tbl[6]  = '{1, 1, 1, 1,   0, 1, 1, 0, 1, 0, 1};
    tbl[7]  = '{1, 1, 1, 1,   1, 1, 0, 1, 1, 0, 1};
    tbl[8]  = '{0, 1, 1, 1,   1, 1, 0, 1, 0, 1, 1};
    tbl[9]  = '{1, 0, 1, 1,   0, 1, 1, 0, 0, 1, 1};
    tbl[10] = '{1, 1, 0, 1,   0, 1, 0, 0, 1, 0, 1};
    tbl[11] = '{0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0};

    do_reset();
    do_reset();
    chk_w("reset_outstanding", 32'(outstanding), 32'h0);
    chk_b("reset_orphan", resp_orphan, 1'b0);

    // Contention: CPU x3 then DMA, repeating; then single-master and backpressure rows.
    foreach (tbl[i]) begin
      step(1'b0, tbl[i].cv, tbl[i].dv, tbl[i].ordy, tbl[i].orv, 32'h100 + i);
      chk_b("tbl_out_valid", o_ov, tbl[i].e_ov);
      if (tbl[i].e_ov) chk_w("tbl_grant_addr", o_addr, tbl[i].e_gdma ? DMA_ADDR : CPU_ADDR);
      chk_b("tbl_cpu_ready", o_cr, tbl[i].e_cr);
      chk_b("tbl_dma_ready", o_dr, tbl[i].e_dr);
      chk_b("tbl_cpu_rvalid", o_crv, tbl[i].e_crv);
      chk_b("tbl_dma_rvalid", o_drv, tbl[i].e_drv);
      chk_w("tbl_outstanding", o_cnt, tbl[i].e_cnt);
    end

    // CPU-only read at RAM latency 1.
    do_reset();
    cpu_if.addr = 32'h8000_0010;
    cpu_if.wen  = 1'b0;
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk_b("rd_out_valid", o_ov, 1'b1);
    chk_w("rd_out_addr", o_addr, 32'h8000_0010);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hCAFE_0001);
    chk_b("rd_cpu_rvalid", o_crv, 1'b1);
    chk_b("rd_dma_rvalid", o_drv, 1'b0);
    chk_w("rd_rdata", o_crdata, 32'hCAFE_0001);

    // Backpressure to full, then one response frees a slot for the next cycle.
    do_reset();
    cpu_if.wen = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      chk_b("bp_accept", o_cr, 1'b1);
    end
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk_b("bp_full_valid", o_ov, 1'b0);
    chk_b("bp_full_ready", o_cr, 1'b0);
    chk_w("bp_full_cnt", o_cnt, 4);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    chk_b("bp_pop_valid", o_ov, 1'b0);
    chk_b("bp_pop_rvalid", o_crv, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk_w("bp_after_cnt", o_cnt, 3);
    chk_b("bp_issue_valid", o_ov, 1'b1);
    chk_b("bp_issue_ready", o_cr, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk_w("bp_drained_cnt", o_cnt, 0);

    // Interleaved CPU, DMA, CPU at RAM latency 2.
    do_reset();
    cpu_if.addr = CPU_ADDR;
    cpu_if.wen  = 1'b0;
    dma_if.wen  = 1'b0;
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA);
    chk_b("il_1_cpu", o_crv, 1'b1);
    chk_b("il_1_dma", o_drv, 1'b0);
    chk_w("il_1_data", o_crdata, 32'hA);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hB);
    chk_b("il_2_cpu", o_crv, 1'b0);
    chk_b("il_2_dma", o_drv, 1'b1);
    chk_w("il_2_data", o_drdata, 32'hB);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hC);
    chk_b("il_3_cpu", o_crv, 1'b1);
    chk_b("il_3_dma", o_drv, 1'b0);
    chk_w("il_3_data", o_crdata, 32'hC);

    // Reset with two requests in flight; later responses become orphans.
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk_w("orph_pre_cnt", o_cnt, 2);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0);
    chk_b("orph_rst_valid", o_ov, 1'b0);
    chk_b("orph_rst_cready", o_cr, 1'b0);
    chk_b("orph_rst_dready", o_dr, 1'b0);
    chk_b("orph_rst_crv", o_crv, 1'b0);
    chk_b("orph_rst_drv", o_drv, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h55);
      chk_b("orph_crv", o_crv, 1'b0);
      chk_b("orph_drv", o_drv, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk_b("orph_flag", o_orphan, 1'b1);
    chk_w("orph_cnt", o_cnt, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk_b("orph_sticky", o_orphan, 1'b1);

    // Random traffic; masters hold valid and payload until accepted.
    do_reset();
    cp = 0;
    dp = 0;
    for (int n = 0; n < 600; n++) begin
      bit ordy, orv;
      if (!cp && $urandom_range(0, 2) != 0) begin
        cp = 1;
        cpu_if.addr  = $urandom;
        cpu_if.wen   = 1'($urandom_range(0, 1));
        cpu_if.wdata = $urandom;
        cpu_if.wmask = 4'($urandom);
      end
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp = 1;
        dma_if.addr  = $urandom;
        dma_if.wen   = 1'($urandom_range(0, 1));
        dma_if.wdata = $urandom;
        dma_if.wmask = 4'($urandom);
      end
      ordy = ($urandom_range(0, 3) != 0);
      orv  = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
      step(1'b0, cp, dp, ordy, orv, $urandom);
      if (e_cacc) cp = 0;
      if (e_dacc) dp = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
